// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package instruction_fetch_unit_pkg;

   localparam int                 WORD_SIZE = 19;
   localparam int                 IM_ADDR_W = 10;
   localparam logic [IM_ADDR_W-1:0] RESET_PC = '0;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_REQ,
      FS_WAIT,
      FS_HOLD
   } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: redirect load beats increment; increment wraps at 2^ADDR_W.
module fetch_pc_reg #(
   parameter int                ADDR_W   = 10,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] load_addr_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] pc_o
);

   logic [ADDR_W-1:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_i)
         pc_d = load_addr_i;
      else if (inc_i)
         pc_d = pc_q + ADDR_W'(1);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_d;
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues single-cycle reads to instruction memory and hands the
// returned word plus its PC to the decoder over valid/ready.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W      = IM_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC    = instruction_fetch_unit_pkg::RESET_PC,
   parameter int                MEM_LATENCY = 1
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic                 halt,
   input  logic                 redirect_valid,
   input  logic [ADDR_W-1:0]    redirect_addr,
   output logic                 im_rd_en,
   output logic [ADDR_W-1:0]    im_addr,
   input  logic [WORD_SIZE-1:0] im_rdata,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   output logic [WORD_SIZE-1:0] instr,
   output logic [ADDR_W-1:0]    instr_pc,
   output logic [ADDR_W-1:0]    pc,
   output logic                 halted
);

   localparam logic [1:0] LAT_INIT = 2'(MEM_LATENCY - 1);

   fetch_state_t          state_q;
   logic [1:0]            lat_cnt_q;
   logic                  rd_en_q;
   logic [ADDR_W-1:0]     addr_q;
   logic                  valid_q;
   logic [WORD_SIZE-1:0]  instr_q;
   logic [ADDR_W-1:0]     instr_pc_q;
   logic [ADDR_W-1:0]     pc_cur;
   logic                  capture;

   // The data beat lands in WAIT once the latency counter has drained.
   assign capture = (state_q == FS_WAIT) && (lat_cnt_q == 2'd0) && !redirect_valid;

   fetch_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .load_i      (redirect_valid),
      .load_addr_i (redirect_addr),
      .inc_i       (capture),
      .pc_o        (pc_cur)
   );

   // The read strobe is raised on the edge that enters REQ, so it is high
   // for exactly the REQ cycle and carries the PC that REQ will fetch.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= FS_IDLE;
         lat_cnt_q  <= 2'd0;
         rd_en_q    <= 1'b0;
         addr_q     <= '0;
         valid_q    <= 1'b0;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else begin
         rd_en_q <= 1'b0;
         if (redirect_valid) begin
            valid_q <= 1'b0;
            if (!halt) begin
               state_q <= FS_REQ;
               rd_en_q <= 1'b1;
               addr_q  <= redirect_addr;
            end else begin
               state_q <= FS_IDLE;
            end
         end else begin
            unique case (state_q)
               FS_IDLE: begin
                  if (!halt) begin
                     state_q <= FS_REQ;
                     rd_en_q <= 1'b1;
                     addr_q  <= pc_cur;
                  end
               end
               FS_REQ: begin
                  lat_cnt_q <= LAT_INIT;
                  state_q   <= FS_WAIT;
               end
               FS_WAIT: begin
                  if (lat_cnt_q != 2'd0) begin
                     lat_cnt_q <= lat_cnt_q - 2'd1;
                  end else begin
                     instr_q    <= im_rdata;
                     instr_pc_q <= pc_cur;
                     valid_q    <= 1'b1;
                     state_q    <= FS_HOLD;
                  end
               end
               FS_HOLD: begin
                  if (instr_ready) begin
                     valid_q <= 1'b0;
                     if (!halt) begin
                        state_q <= FS_REQ;
                        rd_en_q <= 1'b1;
                        addr_q  <= pc_cur;
                     end else begin
                        state_q <= FS_IDLE;
                     end
                  end
               end
               default: state_q <= FS_IDLE;
            endcase
         end
      end
   end

   assign im_rd_en    = rd_en_q;
   assign im_addr     = addr_q;
   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign pc          = pc_cur;
   assign halted      = (state_q == FS_IDLE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: latency-1 and latency-3 fetch units driven side by side.
module tb_instruction_fetch_unit;

   localparam int AW = 10;
   localparam int WS = 19;

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic          halt, redirect_valid, instr_ready;
   logic [AW-1:0] redirect_addr;

   logic          rd1, val1, hlt1;
   logic [AW-1:0] addr1, ipc1, pc1;
   logic [WS-1:0] rdata1, instr1;

   logic          rd3, val3, hlt3;
   logic [AW-1:0] addr3, ipc3, pc3;
   logic [WS-1:0] rdata3, instr3;

   logic [WS-1:0] mem [1024];
   logic          v1;
   logic [AW-1:0] a1;
   logic [2:0]    v3;
   logic [AW-1:0] a3 [3];

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   instruction_fetch_unit #(.ADDR_W(AW), .RESET_PC('0), .MEM_LATENCY(1)) d1 (
      .CLK(CLK), .RESET_N(RESET_N), .halt(halt), .redirect_valid(redirect_valid),
      .redirect_addr(redirect_addr), .im_rd_en(rd1), .im_addr(addr1), .im_rdata(rdata1),
      .instr_valid(val1), .instr_ready(instr_ready), .instr(instr1), .instr_pc(ipc1),
      .pc(pc1), .halted(hlt1));

   instruction_fetch_unit #(.ADDR_W(AW), .RESET_PC('0), .MEM_LATENCY(3)) d3 (
      .CLK(CLK), .RESET_N(RESET_N), .halt(halt), .redirect_valid(redirect_valid),
      .redirect_addr(redirect_addr), .im_rd_en(rd3), .im_addr(addr3), .im_rdata(rdata3),
      .instr_valid(val3), .instr_ready(instr_ready), .instr(instr3), .instr_pc(ipc3),
      .pc(pc3), .halted(hlt3));

   // Memories return data only in the cycle the latency allows; garbage otherwise.
   always @(posedge CLK) begin
      v1    <= rd1;
      a1    <= addr1;
      v3    <= {v3[1:0], rd3};
      a3[0] <= addr3;
      a3[1] <= a3[0];
      a3[2] <= a3[1];
   end
   assign rdata1 = v1    ? mem[a1]    : 19'h7FFFF;
   assign rdata3 = v3[2] ? mem[a3[2]] : 19'h7FFFF;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   initial begin
      for (int k = 0; k < 1024; k++) mem[k] = WS'(k + 'h100);
      v1 = 1'b0; v3 = '0; a1 = '0;
      for (int k = 0; k < 3; k++) a3[k] = '0;
      RESET_N = 1'b0; halt = 1'b0; instr_ready = 1'b1;
      redirect_valid = 1'b0; redirect_addr = '0;
      #2;
      chk("rst_valid",  32'(val1),  0);
      chk("rst_rden",   32'(rd1),   0);
      chk("rst_pc",     32'(pc1),   0);
      chk("rst_halted", 32'(hlt1),  1);
      @(negedge CLK);
      RESET_N = 1'b1;

      // Streaming: latency 1 -> period 3, latency 3 -> period 5.
      for (int c = 1; c <= 15; c++) begin
         step(1);
         chk("l1_rden", 32'(rd1), 32'(c % 3 == 1));
         if (c % 3 == 1) chk("l1_addr", 32'(addr1), 32'((c - 1) / 3));
         chk("l1_valid", 32'(val1), 32'(c % 3 == 0));
         if (c % 3 == 0) begin
            chk("l1_instr", 32'(instr1), 32'('h100 + c / 3 - 1));
            chk("l1_ipc",   32'(ipc1),   32'(c / 3 - 1));
         end
         chk("l3_rden", 32'(rd3), 32'(c % 5 == 1));
         if (c % 5 == 1) chk("l3_addr", 32'(addr3), 32'((c - 1) / 5));
         chk("l3_valid", 32'(val3), 32'(c % 5 == 0));
         if (c % 5 == 0) begin
            chk("l3_instr", 32'(instr3), 32'('h100 + c / 5 - 1));
            chk("l3_ipc",   32'(ipc3),   32'(c / 5 - 1));
         end
      end

      // Backpressure on the instruction fetched from pc 4.
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("bp_instr", 32'(instr1), 'h104);
         chk("bp_ipc",   32'(ipc1),   4);
         chk("bp_valid", 32'(val1),   1);
         chk("bp_rden",  32'(rd1),    0);
      end
      instr_ready = 1'b1;
      step(1);
      chk("bp_rden_after", 32'(rd1),   1);
      chk("bp_addr_after", 32'(addr1), 5);
      step(2);
      chk("pc5_ipc", 32'(ipc1), 5);
      step(3);
      chk("pc6_ipc", 32'(ipc1), 6);
      step(1);
      chk("pc7_addr", 32'(addr1), 7);

      // Redirect to 0x200 while the read of 7 is in flight.
      step(1);
      redirect_valid = 1'b1; redirect_addr = 'h200;
      step(1);
      redirect_valid = 1'b0;
      chk("rd_rden",  32'(rd1),   1);
      chk("rd_addr",  32'(addr1), 'h200);
      chk("rd_valid", 32'(val1),  0);
      chk("rd_pc",    32'(pc1),   'h200);
      step(1);
      chk("rd_novalid", 32'(val1), 0);
      step(1);
      chk("rd_dvalid", 32'(val1),   1);
      chk("rd_instr",  32'(instr1), 'h300);
      chk("rd_ipc",    32'(ipc1),   'h200);
      chk("rd_pcnext", 32'(pc1),    'h201);

      // Redirect in HOLD with ready high: held word is flushed.
      redirect_valid = 1'b1; redirect_addr = 'h010;
      step(1);
      redirect_valid = 1'b0;
      chk("hr_valid", 32'(val1),  0);
      chk("hr_rden",  32'(rd1),   1);
      chk("hr_addr",  32'(addr1), 'h010);
      step(2);
      chk("hr_dvalid", 32'(val1),   1);
      chk("hr_ipc",    32'(ipc1),   'h010);
      chk("hr_instr",  32'(instr1), 'h110);

      // PC wrap from 1023 to 0.
      redirect_valid = 1'b1; redirect_addr = 10'd1023;
      step(1);
      redirect_valid = 1'b0;
      chk("wr_addr", 32'(addr1), 1023);
      step(2);
      chk("wr_ipc",   32'(ipc1),   1023);
      chk("wr_instr", 32'(instr1), 'h4FF);
      chk("wr_pc",    32'(pc1),    0);
      step(3);
      chk("wr_ipc0",   32'(ipc1),   0);
      chk("wr_instr0", 32'(instr1), 'h100);

      // Halt raised during WAIT: the in-flight fetch still delivers.
      step(1);
      chk("ht_addr", 32'(addr1), 1);
      step(1);
      halt = 1'b1;
      step(1);
      chk("ht_valid",  32'(val1),  1);
      chk("ht_ipc",    32'(ipc1),  1);
      chk("ht_nohalt", 32'(hlt1),  0);
      step(1);
      chk("ht_halted", 32'(hlt1), 1);
      chk("ht_valid0", 32'(val1), 0);
      for (int i = 0; i < 4; i++) begin
         chk("ht_norden", 32'(rd1), 0);
         step(1);
      end
      halt = 1'b0;
      step(1);
      chk("rs_rden", 32'(rd1),   1);
      chk("rs_addr", 32'(addr1), 2);
      step(1);

      // Asynchronous reset in the middle of WAIT.
      #1 RESET_N = 1'b0;
      #1;
      chk("ar_valid",  32'(val1),   0);
      chk("ar_instr",  32'(instr1), 0);
      chk("ar_ipc",    32'(ipc1),   0);
      chk("ar_rden",   32'(rd1),    0);
      chk("ar_addr",   32'(addr1),  0);
      chk("ar_pc",     32'(pc1),    0);
      chk("ar_halted", 32'(hlt1),   1);
      @(negedge CLK);
      RESET_N = 1'b1;
      step(1);
      chk("ar_rden_after", 32'(rd1),   1);
      chk("ar_addr_after", 32'(addr1), 0);
      step(2);
      chk("ar_instr_after", 32'(instr1), 'h100);
      chk("ar_ipc_after",   32'(ipc1),   0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
